schedule_player: RTL
====================

// Module: schedule_player
// PURPOSE
//  Replays a completed command schedule out of schedule_memory as an ordered command stream.
//  Drives the memory's rd_cycle address from 0 to max_cycle and absorbs the memory's 1-cycle synchronous read latency.
//  Presents each entry on a valid/ready output for the DRAM command driver or a trace checker.
//  Sits between schedule_memory (read side) and the downstream command consumer.
// PARAMETERS
//  FIFO_DEPTH     2                      output buffer entries; fixed at 2, sized for 1-cycle read latency at full rate
//  CNT_WIDTH      `CYCLE_WIDTH+1         width of the issued-command counter
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  asynchronous active-low reset
//  start          in   1                  1-cycle pulse; begin playback (honoured in IDLE only)
//  abort          in   1                  stop playback and flush; return to IDLE
//  max_cycle      in   `CYCLE_WIDTH       last schedule index; sampled on an accepted start
//  rd_cycle       out  `CYCLE_WIDTH       read address to schedule_memory
//  rd_cmd_type    in   3                  memory read data, valid 1 cycle after address
//  rd_bank_group  in   `BANK_GROUP_WIDTH  memory read data
//  rd_bank        in   `BANK_WIDTH        memory read data
//  rd_row         in   `ROW_WIDTH         memory read data
//  rd_column      in   `COLUMN_WIDTH      memory read data
//  rd_request_id  in   `REQUEST_ID_WIDTH  memory read data
//  out_valid      out  1                  output entry valid
//  out_ready      in   1                  consumer accepts when out_valid&&out_ready
//  out_cycle      out  `CYCLE_WIDTH       schedule index of the output entry
//  out_cmd_type, out_bank_group, out_bank, out_row, out_column, out_request_id
//                 out  as rd_*            output entry payload
//  busy           out  1                  high from accepted start until DONE or abort
//  done           out  1                  1-cycle pulse after the last entry is accepted
//  cmd_count      out  CNT_WIDTH          non-DESELECT entries accepted this playback; saturating
// BEHAVIOUR
//  Reset: rd_cycle=0, out_valid=0, out_cycle=0, payload outputs=0, busy=0, done=0, cmd_count=0, FIFO empty, state IDLE.
//  FSM states:
//   IDLE   start -> latch end=max_cycle, rd_cycle=0, clear cmd_count -> STREAM
//   STREAM issue a read while (fifo_count + inflight) < 2; on issue inflight=1 and rd_cycle++;
//          issuing the read at index end -> DRAIN
//   DRAIN  no further reads; when the FIFO is empty and inflight==0 -> DONE
//   DONE   done=1 for one cycle -> IDLE
//  Read pipeline:
//   - Address is registered; data is pushed with its index tag on the following cycle.
//   - Throughput is 1 entry/cycle while out_ready=1. First out_valid appears 2 cycles after start.
//  Output: out_* is driven from the FIFO head. Data must be held stable while out_valid && !out_ready.
//  cmd_count increments on accept when out_cmd_type != `CMD_DESELECT, and saturates at all-ones.
//  rd_cycle never exceeds the latched end; it holds its last value in DRAIN, DONE and IDLE.
//  Boundaries:
//   - max_cycle=0: exactly one entry (index 0) is output.
//   - start while busy: ignored.
//   - max_cycle changing mid-playback: no effect.
//   - abort has priority over all events: FIFO flushed, inflight read data discarded, out_valid=0 next cycle,
//     -> IDLE, no done pulse, cmd_count held.
//   - abort and start in the same cycle: abort wins.
//   - out_ready stalled indefinitely: no entry lost or duplicated; reads pause.
//   - rst_n asserted mid-playback: all state returns to reset values immediately.
// CONFIGURATION
//  SCHED_PLAYER_SKIP_DESELECT_EN
//   - Defined: entries whose rd_cmd_type==`CMD_DESELECT are read but not pushed. Only real commands appear on out_*,
//     each with its original out_cycle. The credit for a dropped read returns the next cycle.
//     An all-DESELECT schedule gives no out_valid, then done.
//   - Undefined: every index 0..end is output, DESELECT included.
// STRUCTURE
//  Additions to dram_scheduler_types.vh:
//   - PLAYER_IDLE/STREAM/DRAIN/DONE state encodings (2 bits)
//   - `SCHED_ENTRY_WIDTH, the packed {cycle, cmd, bg, bank, row, col, id} width
//  Sub-module schedule_out_fifo: 2-entry FIFO of `SCHED_ENTRY_WIDTH with push, pop, flush, count, and head outputs.
// TESTING
//  - Memory preloaded ACT@0, RD@3, PRE@7; max_cycle=7; out_ready=1; start
//    -> 8 consecutive outputs, out_cycle 0..7, cmd_count=3, done 1 cycle after index 7 is accepted.
//  - Same schedule; out_ready toggles 1,0,0,1 repeating
//    -> index order 0..7 intact, no duplicates, payload stable during stalls.
//  - max_cycle=0, ACT@0
//    -> single output, out_cycle=0, cmd_count=1, done pulse.
//  - Abort asserted 3 cycles after start, out_ready=0
//    -> out_valid=0 next cycle, busy=0, no done; a new start replays from index 0.
//  - Start pulsed again while busy; max_cycle changed 7->3 mid-run
//    -> both ignored, 8 entries output.
//  - With SCHED_PLAYER_SKIP_DESELECT_EN, schedule ACT@2, RD@5, max_cycle=6
//    -> exactly 2 outputs (out_cycle 2 and 5), cmd_count=2, then done.

Source files
------------

// File: rtl/schedule_player_pkg.sv
// Shared types for the schedule player: field widths, command encodings,
// player FSM states and the packed schedule entry carried through the
// output FIFO.
package schedule_player_pkg;

  localparam int unsigned CYCLE_WIDTH      = 8;
  localparam int unsigned BANK_GROUP_WIDTH = 2;
  localparam int unsigned BANK_WIDTH       = 2;
  localparam int unsigned ROW_WIDTH        = 16;
  localparam int unsigned COLUMN_WIDTH     = 10;
  localparam int unsigned REQUEST_ID_WIDTH = 8;

  typedef enum logic [2:0] {
    CMD_DESELECT = 3'd0,
    CMD_ACT      = 3'd1,
    CMD_RD       = 3'd2,
    CMD_WR       = 3'd3,
    CMD_PRE      = 3'd4,
    CMD_REF      = 3'd5
  } cmd_type_e;

  typedef enum logic [1:0] {
    PLAYER_IDLE   = 2'd0,
    PLAYER_STREAM = 2'd1,
    PLAYER_DRAIN  = 2'd2,
    PLAYER_DONE   = 2'd3
  } player_state_e;

  typedef struct packed {
    logic [CYCLE_WIDTH-1:0]      cycle;
    logic [2:0]                  cmd_type;
    logic [BANK_GROUP_WIDTH-1:0] bank_group;
    logic [BANK_WIDTH-1:0]       bank;
    logic [ROW_WIDTH-1:0]        row;
    logic [COLUMN_WIDTH-1:0]     column;
    logic [REQUEST_ID_WIDTH-1:0] request_id;
  } sched_entry_t;

  localparam int unsigned SCHED_ENTRY_WIDTH = $bits(sched_entry_t);

  // True for entries that carry a real DRAM command.
  function automatic logic is_real_cmd(input logic [2:0] cmd_type);
    return cmd_type != CMD_DESELECT;
  endfunction

endpackage

// File: rtl/schedule_player_out_fifo.sv
// schedule_out_fifo: two-entry output buffer for the schedule player.
// Push, pop and flush; head is always the oldest entry, so it stays stable
// while the consumer stalls.
module schedule_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against occupancy; a push into a full FIFO is allowed
  // only when a pop frees a slot in the same cycle.
  always_comb begin
    empty   = (count == 2'd0);
    full    = (count == 2'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  // Storage, pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/schedule_player.sv
// schedule_player: replays a finished schedule from schedule_memory as an
// ordered valid/ready command stream. Walks rd_cycle from 0 to the latched
// end index, absorbs the 1-cycle memory read latency with one in-flight
// credit plus a 2-entry output FIFO, and counts accepted real commands.
// Optional feature macro: SCHED_PLAYER_SKIP_DESELECT_EN drops DESELECT
// entries after the read so only real commands reach the output.
module schedule_player
  import schedule_player_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = CYCLE_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CYCLE_WIDTH-1:0]      max_cycle,
  output logic [CYCLE_WIDTH-1:0]      rd_cycle,
  input  logic [2:0]                  rd_cmd_type,
  input  logic [BANK_GROUP_WIDTH-1:0] rd_bank_group,
  input  logic [BANK_WIDTH-1:0]       rd_bank,
  input  logic [ROW_WIDTH-1:0]        rd_row,
  input  logic [COLUMN_WIDTH-1:0]     rd_column,
  input  logic [REQUEST_ID_WIDTH-1:0] rd_request_id,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CYCLE_WIDTH-1:0]      out_cycle,
  output logic [2:0]                  out_cmd_type,
  output logic [BANK_GROUP_WIDTH-1:0] out_bank_group,
  output logic [BANK_WIDTH-1:0]       out_bank,
  output logic [ROW_WIDTH-1:0]        out_row,
  output logic [COLUMN_WIDTH-1:0]     out_column,
  output logic [REQUEST_ID_WIDTH-1:0] out_request_id,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_WIDTH-1:0]        cmd_count
);

  player_state_e          state;
  logic [CYCLE_WIDTH-1:0] end_cycle;
  logic [CYCLE_WIDTH-1:0] inflight_cycle;
  logic                   inflight;

  sched_entry_t           push_entry;
  sched_entry_t           head_entry;
  logic                   push;
  logic                   pop;
  logic                   issue;
  logic                   drain_empty;
  logic [1:0]             fifo_count;
  logic [2:0]             occupancy;
  logic [2:0]             credit_limit;

  // Handshake, read credit and FIFO push qualification.
  always_comb begin
    pop          = (fifo_count != 2'd0) && out_ready && !abort;
    occupancy    = {1'b0, fifo_count} + {2'b00, inflight};
    // A pop in this cycle frees a slot in time for the read issued now,
    // which keeps the pipeline at one entry per cycle.
    credit_limit = 3'(FIFO_DEPTH) + {2'b00, pop};
    issue        = (state == PLAYER_STREAM) && !abort && (occupancy < credit_limit);
    drain_empty  = !inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

    push_entry.cycle      = inflight_cycle;
    push_entry.cmd_type   = rd_cmd_type;
    push_entry.bank_group = rd_bank_group;
    push_entry.bank       = rd_bank;
    push_entry.row        = rd_row;
    push_entry.column     = rd_column;
    push_entry.request_id = rd_request_id;

`ifdef SCHED_PLAYER_SKIP_DESELECT_EN
    push = inflight && is_real_cmd(rd_cmd_type);
`else
    push = inflight;
`endif
  end

  schedule_out_fifo #(
    .WIDTH (SCHED_ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (abort),
    .count     (fifo_count),
    .head      (head_entry)
  );

  // Output entry is the FIFO head.
  always_comb begin
    out_valid      = (fifo_count != 2'd0);
    out_cycle      = head_entry.cycle;
    out_cmd_type   = head_entry.cmd_type;
    out_bank_group = head_entry.bank_group;
    out_bank       = head_entry.bank;
    out_row        = head_entry.row;
    out_column     = head_entry.column;
    out_request_id = head_entry.request_id;
  end

  // Playback FSM, read address generation, in-flight tracking and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= PLAYER_IDLE;
      end_cycle      <= '0;
      rd_cycle       <= '0;
      inflight       <= 1'b0;
      inflight_cycle <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cmd_count      <= '0;
    end else if (abort) begin
      // Data for a read already issued arrives next cycle and is dropped
      // because the in-flight flag is cleared here.
      state    <= PLAYER_IDLE;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        inflight_cycle <= rd_cycle;
      end
      if (pop && is_real_cmd(out_cmd_type) && (cmd_count != '1)) begin
        cmd_count <= cmd_count + 1'b1;
      end
      case (state)
        PLAYER_IDLE: begin
          if (start) begin
            end_cycle <= max_cycle;
            rd_cycle  <= '0;
            cmd_count <= '0;
            busy      <= 1'b1;
            state     <= PLAYER_STREAM;
          end
        end
        PLAYER_STREAM: begin
          if (issue) begin
            if (rd_cycle == end_cycle) begin
              state <= PLAYER_DRAIN;
            end else begin
              rd_cycle <= rd_cycle + 1'b1;
            end
          end
        end
        PLAYER_DRAIN: begin
          if (drain_empty) begin
            state <= PLAYER_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= PLAYER_IDLE;
        end
      endcase
    end
  end

endmodule
